// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and constants for the multiply issue controller.
// Holds the FSM state encoding, datapath widths and the default timeout.
package mul_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;
    localparam int REG_W  = 5;

    // Must stay above the 4-cycle multiplier latency
    localparam int TIMEOUT_CYCLES_DEF = 15;
    localparam int CNT_W_DEF          = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        FIX   = 3'd4,
        WB    = 3'd5
    } state_e;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of the EX-side request, multiplier-side and writeback-side signals
// of the multiply issue controller. The controller uses the master view,
// and the surrounding pipeline or multiplier uses the slave view.
interface mul_issue_ctrl_if;
    import mul_ctrl_pkg::*;

    logic                    req;
    logic                    is_signed;
    logic [DATA_W-1:0]       op_a;
    logic [DATA_W-1:0]       op_b;
    logic [REG_W-1:0]        rd_in;
    logic                    flush;
    logic                    stall;
    logic                    mul_start;
    logic [DATA_W-1:0]       mul_a;
    logic [DATA_W-1:0]       mul_b;
    logic                    mul_done;
    logic [PROD_W-1:0]       mul_result;
    logic                    wb_valid;
    logic [REG_W-1:0]        wb_rd;
    logic [DATA_W-1:0]       wb_lo;
    logic [DATA_W-1:0]       wb_hi;
    logic                    wb_ack;
    logic                    err;

    modport master (
        input  req, is_signed, op_a, op_b, rd_in, flush,
        input  mul_done, mul_result, wb_ack,
        output stall, mul_start, mul_a, mul_b,
        output wb_valid, wb_rd, wb_lo, wb_hi, err
    );

    modport slave (
        output req, is_signed, op_a, op_b, rd_in, flush,
        output mul_done, mul_result, wb_ack,
        input  stall, mul_start, mul_a, mul_b,
        input  wb_valid, wb_rd, wb_lo, wb_hi, err
    );

endinterface

// File: rtl/mul_sign_cond.sv
// Combinational sign conditioning for the multiplier path.
// Produces operand magnitudes for a signed multiply and the conditional
// two's-complement negate of the unsigned 64-bit product.
module mul_sign_cond
    import mul_ctrl_pkg::*;
(
    input  logic              is_signed_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] mag_a_o,
    output logic [DATA_W-1:0] mag_b_o,
    input  logic              neg_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [PROD_W-1:0] prod_o
);

    // Negative operands of a signed multiply become their magnitude; the most
    // negative value maps onto itself, which is the correct unsigned magnitude.
    assign mag_a_o = (is_signed_i && a_i[DATA_W-1]) ? (~a_i + DATA_W'(1)) : a_i;
    assign mag_b_o = (is_signed_i && b_i[DATA_W-1]) ? (~b_i + DATA_W'(1)) : b_i;

    // Restore the sign of the product when exactly one operand was negative
    assign prod_o = neg_i ? (~prod_i + PROD_W'(1)) : prod_i;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequencing controller between the EX stage and the iterative multiplier.
// Stalls the front end, issues magnitudes, waits for completion, fixes the
// sign and holds the product on a writeback handshake. Flush and a hung
// multiplier (sticky err) are handled.
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand skips the
// multiplier and goes straight to writeback with a zero product.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mul_issue_ctrl_if.master  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] opA_q, opA_d;
    logic [DATA_W-1:0] opB_q, opB_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] magA;
    logic [DATA_W-1:0] magB;
    logic [PROD_W-1:0] prodFixed;
    logic [CNT_W-1:0]  cntInc;
    logic              timeoutHit;
    logic              mulStart;

    mul_sign_cond u_sign_cond (
        .is_signed_i (bus.is_signed),
        .a_i         (bus.op_a),
        .b_i         (bus.op_b),
        .mag_a_o     (magA),
        .mag_b_o     (magB),
        .neg_i       (neg_q),
        .prod_i      (prod_q),
        .prod_o      (prodFixed)
    );

    assign cntInc     = cnt_q + CNT_W'(1);
    assign timeoutHit = (cntInc == CNT_W'(TIMEOUT_CYCLES));

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; flush always wins over completion or timeout
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rd_d     = rd_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        prod_d   = prod_q;
        err_d    = err_q;
        mulStart = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req && !bus.flush) begin
                    rd_d  = bus.rd_in;
                    neg_d = bus.is_signed & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
                    opA_d = magA;
                    opB_d = magB;
`ifdef MUL_ZERO_BYPASS_EN
                    if (bus.op_a == '0 || bus.op_b == '0) begin
                        prod_d  = '0;
                        state_d = WB;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    mulStart = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cntInc;
                if (bus.flush) begin
                    // A done arriving with the flush is already consumed
                    state_d = bus.mul_done ? IDLE : DRAIN;
                end else if (bus.mul_done) begin
                    prod_d  = bus.mul_result;
                    state_d = FIX;
                end else if (timeoutHit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                cnt_d = cntInc;
                if (bus.mul_done) begin
                    state_d = IDLE;
                end else if (timeoutHit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            FIX: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d  = prodFixed;
                    state_d = WB;
                end
            end
            WB: begin
                if (bus.flush || bus.wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall     = (state_q != IDLE) || (bus.req && !bus.flush);
    assign bus.mul_start = mulStart;
    assign bus.mul_a     = opA_q;
    assign bus.mul_b     = opB_q;
    assign bus.wb_valid  = (state_q == WB) && !bus.flush;
    assign bus.wb_rd     = rd_q;
    assign bus.wb_lo     = prod_q[DATA_W-1:0];
    assign bus.wb_hi     = prod_q[PROD_W-1:DATA_W];
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed testbench for mul_issue_ctrl. The bench plays both the EX stage
// and the multiplier; expected values are hand-computed constants.
module tb_mul_issue_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   startCount = 0;

    mul_issue_ctrl_if bus ();

    mul_issue_ctrl #(
        .TIMEOUT_CYCLES (15),
        .CNT_W          (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count start pulses seen by the multiplier
    always @(posedge clk) begin
        if (bus.mul_start === 1'b1) startCount <= startCount + 1;
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic req, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input logic flush);
        bus.req       = req;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.rd_in     = rd;
        bus.flush     = flush;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full multiply with the multiplier answering in cycle 5 and ack in cycle 7
    task automatic runMul(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [63:0] raw,
                          input logic [31:0] expMa, input logic [31:0] expMb,
                          input logic [31:0] expHi, input logic [31:0] expLo);
        int startsBefore;
        startsBefore = startCount;
        nextCycle();
        applyStimulus(1'b1, sgn, a, b, rd, 1'b0);
        midCycle();
        checkOutput({tag, ".stall_c0"}, 64'(bus.stall), 64'd1);
        checkOutput({tag, ".start_c0"}, 64'(bus.mul_start), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        midCycle();
        checkOutput({tag, ".start_c1"}, 64'(bus.mul_start), 64'd1);
        checkOutput({tag, ".mul_a"}, 64'(bus.mul_a), 64'(expMa));
        checkOutput({tag, ".mul_b"}, 64'(bus.mul_b), 64'(expMb));
        for (int i = 2; i <= 4; i++) begin
            nextCycle();
            midCycle();
            checkOutput({tag, ".stall_wait"}, 64'(bus.stall), 64'd1);
            checkOutput({tag, ".start_wait"}, 64'(bus.mul_start), 64'd0);
            checkOutput({tag, ".mul_a_hold"}, 64'(bus.mul_a), 64'(expMa));
        end
        nextCycle();
        bus.mul_done   = 1'b1;
        bus.mul_result = raw;
        midCycle();
        checkOutput({tag, ".wbv_c5"}, 64'(bus.wb_valid), 64'd0);
        nextCycle();
        bus.mul_done   = 1'b0;
        bus.mul_result = 64'h0;
        midCycle();
        checkOutput({tag, ".wbv_c6"}, 64'(bus.wb_valid), 64'd0);
        checkOutput({tag, ".stall_c6"}, 64'(bus.stall), 64'd1);
        nextCycle();
        bus.wb_ack = 1'b1;
        midCycle();
        checkOutput({tag, ".wbv_c7"}, 64'(bus.wb_valid), 64'd1);
        checkOutput({tag, ".wb_hi"}, 64'(bus.wb_hi), 64'(expHi));
        checkOutput({tag, ".wb_lo"}, 64'(bus.wb_lo), 64'(expLo));
        checkOutput({tag, ".wb_rd"}, 64'(bus.wb_rd), 64'(rd));
        checkOutput({tag, ".stall_c7"}, 64'(bus.stall), 64'd1);
        nextCycle();
        bus.wb_ack = 1'b0;
        midCycle();
        checkOutput({tag, ".stall_c8"}, 64'(bus.stall), 64'd0);
        checkOutput({tag, ".wbv_c8"}, 64'(bus.wb_valid), 64'd0);
        checkOutput({tag, ".start_pulses"}, 64'(startCount - startsBefore), 64'd1);
    endtask

    // Directed sequence
    initial begin
        int startsBefore;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        bus.mul_done   = 1'b0;
        bus.mul_result = 64'h0;
        bus.wb_ack     = 1'b0;

        midCycle();
        checkOutput("rst.stall", 64'(bus.stall), 64'd0);
        checkOutput("rst.start", 64'(bus.mul_start), 64'd0);
        checkOutput("rst.wbv", 64'(bus.wb_valid), 64'd0);
        checkOutput("rst.err", 64'(bus.err), 64'd0);
        checkOutput("rst.mul_a", 64'(bus.mul_a), 64'd0);
        checkOutput("rst.wb_lo", 64'(bus.wb_lo), 64'd0);
        nextCycle();
        reset = 1'b0;

        runMul("multu", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 64'h0000_0001_FFFF_FFFE,
               32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        runMul("mult_neg", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 5'd9, 64'h0000_0000_0000_0015,
               32'h0000_0003, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runMul("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd31, 64'h4000_0000_0000_0000,
               32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Flush in WAIT cycle 3, done discarded in DRAIN
        startsBefore = startCount;
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0004, 32'h0000_0005, 5'd3, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        nextCycle();
        nextCycle();
        bus.flush = 1'b1;
        midCycle();
        checkOutput("flush.stall_c3", 64'(bus.stall), 64'd1);
        nextCycle();
        bus.flush = 1'b0;
        midCycle();
        checkOutput("flush.stall_drain", 64'(bus.stall), 64'd1);
        nextCycle();
        bus.mul_done   = 1'b1;
        bus.mul_result = 64'h14;
        midCycle();
        checkOutput("flush.stall_done", 64'(bus.stall), 64'd1);
        checkOutput("flush.wbv_done", 64'(bus.wb_valid), 64'd0);
        nextCycle();
        bus.mul_done   = 1'b0;
        bus.mul_result = 64'h0;
        midCycle();
        checkOutput("flush.stall_after", 64'(bus.stall), 64'd0);
        checkOutput("flush.wbv_after", 64'(bus.wb_valid), 64'd0);
        checkOutput("flush.starts", 64'(startCount - startsBefore), 64'd1);
        // Stray done in IDLE must be ignored
        nextCycle();
        bus.mul_done   = 1'b1;
        bus.mul_result = 64'hDEAD;
        nextCycle();
        bus.mul_done   = 1'b0;
        bus.mul_result = 64'h0;
        midCycle();
        checkOutput("stray_done.stall", 64'(bus.stall), 64'd0);
        checkOutput("stray_done.wbv", 64'(bus.wb_valid), 64'd0);

        // Hung multiplier: 15 WAIT cycles (cycles 2..16) then abort
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0002, 32'h0000_0003, 5'd4, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 2; i <= 16; i++) nextCycle();
        midCycle();
        checkOutput("timeout.err_c16", 64'(bus.err), 64'd0);
        checkOutput("timeout.stall_c16", 64'(bus.stall), 64'd1);
        nextCycle();
        midCycle();
        checkOutput("timeout.err_c17", 64'(bus.err), 64'd1);
        checkOutput("timeout.stall_c17", 64'(bus.stall), 64'd0);
        checkOutput("timeout.wbv_c17", 64'(bus.wb_valid), 64'd0);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("timeout.err_reset", 64'(bus.err), 64'd0);
        nextCycle();
        reset = 1'b0;

        // Writeback held for 5 cycles without ack
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010, 5'd7, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 2; i <= 4; i++) nextCycle();
        nextCycle();
        bus.mul_done   = 1'b1;
        bus.mul_result = 64'h100;
        nextCycle();
        bus.mul_done   = 1'b0;
        bus.mul_result = 64'h0;
        for (int i = 7; i <= 11; i++) begin
            nextCycle();
            midCycle();
            checkOutput("hold.wbv", 64'(bus.wb_valid), 64'd1);
            checkOutput("hold.stall", 64'(bus.stall), 64'd1);
            checkOutput("hold.wb_lo", 64'(bus.wb_lo), 64'h100);
            checkOutput("hold.wb_hi", 64'(bus.wb_hi), 64'h0);
            checkOutput("hold.wb_rd", 64'(bus.wb_rd), 64'd7);
        end
        nextCycle();
        bus.wb_ack = 1'b1;
        midCycle();
        checkOutput("hold.wbv_ack", 64'(bus.wb_valid), 64'd1);
        nextCycle();
        bus.wb_ack = 1'b0;
        midCycle();
        checkOutput("hold.stall_after", 64'(bus.stall), 64'd0);

        // Asynchronous reset in the middle of WAIT
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0009, 32'h0000_0009, 5'd2, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        nextCycle();
        nextCycle();
        midCycle();
        checkOutput("areset.stall_before", 64'(bus.stall), 64'd1);
        checkOutput("areset.mul_a_before", 64'(bus.mul_a), 64'd9);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("areset.stall", 64'(bus.stall), 64'd0);
        checkOutput("areset.mul_a", 64'(bus.mul_a), 64'd0);
        checkOutput("areset.mul_b", 64'(bus.mul_b), 64'd0);
        checkOutput("areset.wb_lo", 64'(bus.wb_lo), 64'd0);
        checkOutput("areset.wb_rd", 64'(bus.wb_rd), 64'd0);
        checkOutput("areset.wbv", 64'(bus.wb_valid), 64'd0);
        checkOutput("areset.err", 64'(bus.err), 64'd0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Sequencing controller between the EX stage and the 4-state iterative multiplier.
- Accepts one multiply request from EX and stalls the front of the pipeline.
- Converts signed operands to magnitudes and pulses the multiplier's start input.
- Waits for done, applies the sign correction and holds the 64-bit product on a writeback handshake until it is accepted.
- Handles pipeline flush and a hung multiplier.

Parameters:
- TIMEOUT_CYCLES, 15, max cycles in WAIT/DRAIN before abort (must exceed multiplier latency of 4).
- CNT_W, 4, width of timeout counter; TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  EX holds a MULT/MULTU instruction.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU.
- op_a  in  32  operand A.
- op_b  in  32  operand B.
- rd_in  in  5  destination register of the request.
- flush  in  1  squash the in-flight multiply.
- stall  out  1  freeze IF/ID/EX.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_a  out  32  operand magnitude A to multiplier.
- mul_b  out  32  operand magnitude B to multiplier.
- mul_done  in  1  multiplier completion.
- mul_result  in  64  unsigned product from multiplier.
- wb_valid  out  1  result available for writeback.
- wb_rd  out  5  destination register.
- wb_lo  out  32  product bits 31..0.
- wb_hi  out  32  product bits 63..32.
- wb_ack  in  1  writeback accepted.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all outputs 0, latched operands/rd/neg/product 0, err=0.
- stall = (state != IDLE) | (state == IDLE & req & ~flush). Combinational, so it asserts in the same cycle req is first seen.
- IDLE:
  - On req & ~flush: latch rd_in and neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Latch mul_a/mul_b = two's-complement magnitude when is_signed and the operand is negative, else raw. Magnitude of 0x80000000 is 0x80000000, with no overflow.
  - Go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle; mul_a/mul_b stable from ISSUE through WAIT; counter cleared; go to WAIT. If flush in ISSUE: mul_start suppressed, go to IDLE.
- WAIT:
  - Counter increments each cycle.
  - On mul_done: capture mul_result and go to FIX.
  - Counter == TIMEOUT_CYCLES without done: err<=1, go to IDLE, no writeback.
  - flush: go to DRAIN.
- DRAIN: wait for mul_done and discard it, then go to IDLE. The timeout also applies here (sets err). stall remains 1.
- FIX: product = neg ? (~p + 1) mod 2^64 : p. Go to WB. flush: go to IDLE.
- WB:
  - wb_valid=1; wb_rd/wb_lo/wb_hi held stable until wb_ack.
  - wb_ack: go to IDLE, so stall deasserts the next cycle.
  - flush (with or without ack): go to IDLE, drop wb_valid, no write.
- Latency without stalls on wb_ack: req in cycle 0 gives mul_start in cycle 1, mul_done in cycle 5 (multiplier: 4 states), FIX in cycle 6, wb_valid in cycle 7.
- mul_done outside WAIT/DRAIN is ignored.
- req while state != IDLE is ignored; stall guarantees EX holds it.

Optional Feature:
- MUL_ZERO_BYPASS_EN defined: in IDLE, if op_a==0 or op_b==0, skip ISSUE/WAIT/FIX. Go directly to WB with product 0 (wb_valid the cycle after req), and never pulse mul_start.
- Undefined: zero operands take the normal path.

Decomposition:
- Package mul_ctrl_pkg holds:
  - state encoding: IDLE, ISSUE, WAIT, DRAIN, FIX, WB (3-bit);
  - DATA_W=32, PROD_W=64, REG_W=5;
  - default TIMEOUT_CYCLES.
- One combinational sub-module, mul_sign_cond, provides the 32-bit conditional magnitude and the 64-bit conditional negate. It is instantiated for both operand conditioning and product fix.

Test Plan:
- MULTU 0xFFFFFFFF x 0x00000002 -> one mul_start pulse; wb_hi=0x00000001, wb_lo=0xFFFFFFFE; wb_valid in cycle 7; stall high cycles 0-7.
- MULT -3 x 7 -> mul_a=3, mul_b=7; wb_hi=0xFFFFFFFF, wb_lo=0xFFFFFFEB.
- MULT 0x80000000 x 0x80000000 -> mul_a=mul_b=0x80000000; product 0x4000000000000000.
- flush in WAIT cycle 3 -> DRAIN, mul_done discarded, no wb_valid, stall drops the cycle after done.
- mul_done never asserted -> err=1 after 15 WAIT cycles, return to IDLE, stall drops; reset clears err.
- wb_ack withheld 5 cycles -> wb_* stable, stall held; async reset mid-WAIT -> all outputs 0 immediately.
